// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register command sequencer.
// Contents: op/sel encoding, sequencer FSM states, register width and the
// LFSR lock-up value.
package shift_reg_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 3;

    // All-zero state the LFSR can never leave.
    localparam logic [REG_W-1:0] LFSR_ZERO = 5'b00000;

    // Command op codes; the same values drive the register's sel input.
    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 3'b000,
        OP_SHR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_LOAD = 3'b011,
        OP_LFSR = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Codes above OP_LFSR have no register mode behind them.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_LFSR);
    endfunction

endpackage

// File: rtl/shift_reg_sequencer_step_timer.sv
// step_timer: counts the clk cycles of one multi-cycle step and pulses a
// registered strobe on the last cycle of every step.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   run       - timer is active in the NEXT cycle (driven from next-state logic)
//   strobe    - registered, high on cycle STEP_CYCLES-1 of each step
module step_timer #(
    parameter int unsigned STEP_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic strobe
);

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q;
    logic          strobe_q, strobe_d;

    // A fresh run starts at 0; a continuing run wraps at STEP_CYCLES-1.
    always_comb begin
        cnt_d    = '0;
        strobe_d = 1'b0;
        if (run && run_q) begin
            cnt_d = (cnt_q == CW'(STEP_CYCLES - 1)) ? '0 : cnt_q + CW'(1);
        end
        if (run) begin
            strobe_d = (cnt_d == CW'(STEP_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            run_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            run_q    <= run;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: accepts one command at a time and drives the 5-stage
// shift register's sel / parallel inputs for the required number of steps,
// then pulses done with a snapshot of the register outputs.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake
//   cmd_op/count/data     - op code, step count, parallel load value
//   sel, par_data         - to register mode select and ip1..ip5
//   reg_q                 - from register out1..out5
//   step_strobe           - last cycle of each step
//   busy, done, err       - status; err qualified by done
//   result                - reg_q captured in the DONE cycle
module shift_reg_sequencer
    import shift_reg_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 5,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [4:0]       cmd_data,
    output logic [2:0]       sel,
    output logic [4:0]       par_data,
    input  logic [4:0]       reg_q,
    output logic             step_strobe,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [4:0]       result
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [REG_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [OP_W-1:0]   sel_q, sel_d;
    logic [REG_W-1:0]  par_q, par_d;
    logic [REG_W-1:0]  result_q, result_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              run_c;
    logic              strobe;

    assign run_c = (state_d == ST_STEP);

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (run_c),
        .strobe (strobe)
    );

    // Next state, command latch, remaining-steps counter and result capture.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        rem_d    = rem_q;
        result_d = result_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    rem_d  = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;
                    if (!op_legal(cmd_op) ||
                        (cmd_op == OP_LFSR && reg_q == LFSR_ZERO)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (cmd_op == OP_HOLD ||
                                 (cmd_op != OP_LOAD && cmd_count == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                if (strobe) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                result_d = reg_q;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register cleanly.
        sel_d   = (state_d == ST_STEP) ? op_d : OP_HOLD;
        par_d   = (state_d == ST_STEP && op_d == OP_LOAD) ? data_d : '0;
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            data_q   <= '0;
            rem_q    <= '0;
            sel_q    <= OP_HOLD;
            par_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            sel_q    <= sel_d;
            par_q    <= par_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign sel         = sel_q;
    assign par_data    = par_q;
    assign step_strobe = strobe;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Testbench for shift_reg_sequencer: table-driven command vectors, hand
// sequences for mid-operation reset and back-to-back commands, and random
// traffic, all shadowed by a per-cycle expected-trace model.
module tb_shift_reg_sequencer;
    import shift_reg_pkg::*;

    localparam int unsigned S     = 5;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [4:0]       cmd_data;
    logic [2:0]       sel;
    logic [4:0]       par_data;
    logic [4:0]       reg_q;
    logic             step_strobe;
    logic             busy;
    logic             done;
    logic             err;
    logic [4:0]       result;

    shift_reg_sequencer #(
        .STEP_CYCLES(S),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .cmd_data   (cmd_data),
        .sel        (sel),
        .par_data   (par_data),
        .reg_q      (reg_q),
        .step_strobe(step_strobe),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- per-cycle expected-trace model ----------------
    typedef struct packed {
        logic       ready;
        logic [2:0] sel;
        logic [4:0] par;
        logic       strobe;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    obs_t       exp_q[$];
    logic [4:0] model_result = '0;
    bit         armed = 1'b0;

    function automatic obs_t idle_obs();
        obs_t o;
        o       = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic obs_t done_obs(input logic e);
        obs_t o;
        o      = '0;
        o.busy = 1'b1;
        o.done = 1'b1;
        o.err  = e;
        return o;
    endfunction

    // An accepted command becomes a list of expected cycles: N*S stepping
    // cycles (strobe every S-th) followed by one DONE cycle.
    function automatic void expand(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                                   input logic [4:0] d, input logic [4:0] rq);
        obs_t o;
        int   n;
        if (op > 3'd4 || (op == OP_LFSR && rq == 5'd0)) begin
            exp_q.push_back(done_obs(1'b1));
            return;
        end
        if (op == OP_LOAD)      n = 1;
        else if (op == OP_HOLD) n = 0;
        else                    n = int'(cnt);
        for (int k = 1; k <= n * int'(S); k++) begin
            o        = '0;
            o.sel    = op;
            o.par    = (op == OP_LOAD) ? d : 5'd0;
            o.strobe = ((k % int'(S)) == 0);
            o.busy   = 1'b1;
            exp_q.push_back(o);
        end
        exp_q.push_back(done_obs(1'b0));
    endfunction

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (armed) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs();
            a.ready  = cmd_ready;
            a.sel    = sel;
            a.par    = par_data;
            a.strobe = step_strobe;
            a.busy   = busy;
            a.done   = done;
            a.err    = e.done ? err : e.err;
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL trace: got rdy/sel/par/stb/busy/done/err=%b, expected %b (t=%0t)",
                         a, e, $time);
            end
            n_cmp++;
            if (result !== model_result) begin
                n_fail++;
                $display("FAIL trace_result: got %b, expected %b (t=%0t)", result, model_result, $time);
            end
            if (e.done) model_result = reg_q;
            if (!rst && e.ready && cmd_valid) expand(cmd_op, cmd_count, cmd_data, reg_q);
        end
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(obs_t'(0));
            model_result = '0;
            armed        = 1'b1;
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]       op;
        logic [CNT_W-1:0] cnt;
        logic [4:0]       data;
        logic [4:0]       rq;
        int               lat;
        bit               err;
        int               strobes;
    } vec_t;

    vec_t vecs[10];

    task automatic run_cmd(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                           input logic [4:0] d, output int lat, output bit e,
                           output int strobes, output bit timed_out);
        int w;
        timed_out = 1'b0;
        lat       = 0;
        strobes   = 0;
        e         = 1'b0;
        @(posedge clk); #1;
        cmd_op = op; cmd_count = cnt; cmd_data = d; cmd_valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!cmd_ready && w < 50);
        if (!cmd_ready) timed_out = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!timed_out) begin
            @(negedge clk);
            lat++;
            if (step_strobe) strobes++;
            if (done) begin
                e = err;
                break;
            end
            if (lat > 300) timed_out = 1'b1;
        end
    endtask

    initial begin
        int  lat, strobes, c, done_c, w;
        bit  e, to;
        logic [4:0] rq_a;

        vecs[0] = '{OP_LOAD, 8'd9, 5'b10110, 5'b00001,  6, 1'b0, 1};
        vecs[1] = '{OP_SHR,  8'd3, 5'b00000, 5'b00001, 16, 1'b0, 3};
        vecs[2] = '{OP_SHL,  8'd0, 5'b00000, 5'b00001,  1, 1'b0, 0};
        vecs[3] = '{OP_HOLD, 8'd2, 5'b11111, 5'b00001,  1, 1'b0, 0};
        vecs[4] = '{3'b110,  8'd2, 5'b00000, 5'b00001,  1, 1'b1, 0};
        vecs[5] = '{OP_LFSR, 8'd3, 5'b00000, 5'b00000,  1, 1'b1, 0};
        vecs[6] = '{OP_LFSR, 8'd2, 5'b00000, 5'b10011, 11, 1'b0, 2};
        vecs[7] = '{3'b101,  8'd1, 5'b00000, 5'b00100,  1, 1'b1, 0};
        vecs[8] = '{OP_SHL,  8'd1, 5'b00000, 5'b00100,  6, 1'b0, 1};
        vecs[9] = '{OP_LFSR, 8'd0, 5'b00000, 5'b01000,  1, 1'b0, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0;
        cmd_data = '0; reg_q = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", int'(cmd_ready), 0);
        check("reset_sel", int'(sel), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_result", int'(result), 0);
        @(negedge clk);
        check("post_reset_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 10; i++) begin
            reg_q = vecs[i].rq;
            run_cmd(vecs[i].op, vecs[i].cnt, vecs[i].data, lat, e, strobes, to);
            check($sformatf("vec%0d_timeout", i), int'(to), 0);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_err", i), int'(e), int'(vecs[i].err));
            check($sformatf("vec%0d_strobes", i), strobes, vecs[i].strobes);
        end

        // Reset in the middle of an SHR count=4.
        reg_q = 5'b00110;
        @(posedge clk); #1;
        cmd_op = OP_SHR; cmd_count = 8'd4; cmd_data = '0; cmd_valid = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!cmd_ready && w < 50);
        check("midrst_accept", int'(cmd_ready), 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        c = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) c++;
            @(posedge clk);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        if (done) c++;
        check("midrst_sel_before", int'(sel), int'(OP_SHR));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_sel", int'(sel), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_result", int'(result), 0);
        @(negedge clk);
        check("midrst_ready", int'(cmd_ready), 1);
        repeat (25) begin
            @(negedge clk);
            if (done) c++;
        end
        check("midrst_no_done", c, 0);

        // Back-to-back: cmd_valid held high across two commands.
        @(posedge clk); #1;
        reg_q = 5'b01010;
        cmd_op = OP_SHL; cmd_count = 8'd1; cmd_data = '0; cmd_valid = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!cmd_ready && w < 50);
        @(posedge clk); #1;
        cmd_op = OP_LOAD; cmd_data = 5'b00111; cmd_count = 8'd0;
        done_c = -1;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (done) begin done_c = k; break; end
        end
        check("b2b_done_a", done_c, 6);
        rq_a = reg_q;
        @(posedge clk); #1 reg_q = 5'b11001;
        @(negedge clk);
        check("b2b_accept_next_cycle", int'(cmd_ready && cmd_valid), 1);
        check("b2b_result_a", int'(result), int'(rq_a));
        @(posedge clk); #1 cmd_valid = 1'b0;
        done_c = -1;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (done) begin done_c = k; break; end
        end
        check("b2b_done_b", done_c, 6);
        @(negedge clk);
        check("b2b_result_b", int'(result), 5'b11001);

        // Random traffic with a reset dropped in partway.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            reg_q     = 5'($urandom);
            cmd_valid = ($urandom_range(2, 0) == 0);
            cmd_op    = 3'($urandom_range(7, 0));
            cmd_count = CNT_W'($urandom_range(3, 0));
            cmd_data  = 5'($urandom);
            rst       = (i == 300);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; rst = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command sequencer for the 5-stage multi-operational shift register. Accepts one command at a time over a valid/ready handshake: parallel load, shift right, shift left, LFSR step or hold. It drives the register's 3-bit `sel` and 5-bit parallel inputs for exactly the required number of steps, then reports completion with a snapshot of the register outputs. It sits between the system control path and the register instance and is the only driver of that register's `sel` and `ip1..ip5`.

## Interface

Parameters:
- `STEP_CYCLES`, default 5: clk cycles per register step, one per pulse phase; legal range ≥1.
- `CNT_W`, default 8: width of the step count.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: sequencer can accept a command.
- `cmd_op`, input, 3: operation code.
- `cmd_count`, input, CNT_W: number of steps for shift and LFSR ops.
- `cmd_data`, input, 5: parallel load value.
- `sel`, output, 3: register mode select.
- `par_data`, output, 5: to register `ip1..ip5`; bit 0 maps to `ip1`.
- `reg_q`, input, 5: register `out1..out5`; bit 0 is `out1`.
- `step_strobe`, output, 1: one-cycle pulse on the last cycle of each step.
- `busy`, output, 1: high from the cycle after acceptance through the DONE cycle.
- `done`, output, 1: one-cycle completion pulse.
- `err`, output, 1: valid only while `done` is high.
- `result`, output, 5: `reg_q` captured in the DONE cycle; held until the next DONE.

## Operation

Op / sel encoding (identical values):
- HOLD 3'b000
- SHR 3'b001
- SHL 3'b010
- LOAD 3'b011
- LFSR 3'b100
- 3'b101–3'b111 are illegal.

FSM states: IDLE, STEP, DONE.
- **IDLE:** `cmd_ready`=1 and `sel`=HOLD. A handshake (`cmd_valid`&&`cmd_ready`) latches op, count and data.
  - Legal op with work to do → STEP.
  - Otherwise → DONE. This covers HOLD, illegal op, and SHR/SHL/LFSR with count 0.
- **STEP:** `sel`=latched op.
  - A cycle counter runs 0..STEP_CYCLES-1. On value STEP_CYCLES-1, `step_strobe`=1 and the remaining-steps counter decrements.
  - When the remaining count reaches 0 after a strobe → DONE.
  - LOAD always executes exactly one step, ignoring `cmd_count`.
  - `par_data` = latched data during a LOAD step, and 0 in every other state.
- **DONE:** `sel`=HOLD, `done`=1, `result`<=`reg_q`, `cmd_ready`=0 → IDLE.

`err` is set in DONE for:
- an illegal op;
- an LFSR op whose `reg_q` was 5'b00000 at acceptance (lock-up state). No steps are run in this case.

Count 0 on SHR/SHL/LFSR is not an error: `done` with `err`=0.

## Timing

Reset values (sync, `rst`=1 at an edge):
- FSM=IDLE, `sel`=HOLD, `par_data`=0, `cmd_ready`=0 during reset and 1 the cycle after.
- `step_strobe`=0, `busy`=0, `done`=0, `err`=0, `result`=0, all counters 0.

Latency, with acceptance at edge T:
- Stepping op with N steps (LOAD: N=1): `sel`=op for cycles T+1..T+N·STEP_CYCLES; DONE at T+N·STEP_CYCLES+1.
- No-step op (HOLD, illegal, count 0, LFSR lock-up): DONE at T+1.
- Next command can be accepted at T_done+1. Throughput is one command per (N·STEP_CYCLES+2) cycles.

`sel` is registered and changes only on step boundaries, so it never glitches within a step.

Reset mid-STEP: `sel` returns to HOLD at the reset edge. No `done` pulse is issued and the partial step is abandoned. `result` resets to 0.

`cmd_valid` without `cmd_ready` is ignored. Nothing is queued.

## Structure

Package `shift_reg_pkg`:
- op/sel enum;
- FSM state enum;
- `REG_W`=5;
- `LFSR_ZERO`=5'b00000.

Sub-module `step_timer`: the STEP_CYCLES cycle counter with strobe output. Reusable by other multi-phase users.

The top contains the FSM, the remaining-steps counter, the command latch and the result capture. Estimated total RTL is 150–250 lines.

## Test plan

- **Reset then LOAD:** LOAD data=5'b10110 accepted at T. Expected: `sel`=3'b011 and `par_data`=5'b10110 for T+1..T+5, `step_strobe` at T+5, `done` at T+6, `err`=0.
- **SHR:** SHR count=3 with STEP_CYCLES=5. Expected: exactly 3 `step_strobe` pulses at T+5, T+10, T+15; `sel`=3'b001 for cycles T+1..T+15; `done` at T+16; `cmd_ready`=0 throughout.
- **Zero-count and no-op ops:** SHL count=0 → `done` at T+1, `err`=0, `sel` stays HOLD. HOLD op → same. Op 3'b110 → `done` at T+1 with `err`=1.
- **LFSR lock-up:** LFSR with `reg_q`=5'b00000 → `done` at T+1, `err`=1, no strobes. LFSR count=2 with `reg_q`≠0 → 2 strobes, `done` at T+11, `err`=0.
- **Reset mid-operation:** assert `rst` at T+7 of an SHR count=4. Expected: `sel`=HOLD, `busy`=0, no `done`, `cmd_ready`=1 at the cycle after `rst` deasserts.
- **Back-to-back commands:** keep `cmd_valid` high with two commands queued at the source. Expected: the second is accepted exactly one cycle after the first `done`. `result` equals the `reg_q` sampled on each DONE cycle.
